seq_chunk_adder: RTL

//  Multi-cycle, parametrised successor to the combinational full adder.
//  - Adds two WIDTH-bit operands CHUNK bits per clock, through a registered carry chain.
//  - Uses a start/busy/done handshake.
//  - Trades latency for a short combinational path; serves as the shared ALU adder core.

---
 rtl/seq_chunk_adder_pkg.sv | 4 +
 rtl/seq_chunk_adder_if.sv | 31 +++
 rtl/seq_chunk_adder_chunk.sv | 23 ++
 rtl/seq_chunk_adder.sv | 119 +++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types for the sequential chunked adder.
package seq_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_e;
endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle of seq_chunk_adder; the sub signal exists only with SEQ_ADDER_SUBTRACT_EN.
interface seq_chunk_adder_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SEQ_ADDER_SUBTRACT_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
`ifdef SEQ_ADDER_SUBTRACT_EN
      output sub,
`endif
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
`ifdef SEQ_ADDER_SUBTRACT_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
module chunk_adder #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             msb_cin_o
);
   logic [CHUNK:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o    = c[CHUNK];
   assign msb_cin_o = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock through a registered carry.
// Optional subtract path enabled by SEQ_ADDER_SUBTRACT_EN.
module seq_chunk_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic              clk,
   input  logic              rst,
   seq_chunk_adder_if.slave  bus_if
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end
   if ($bits(bus_if.a) != WIDTH) begin : g_bad_if
      $error("seq_chunk_adder: interface WIDTH differs from adder WIDTH");
   end

   sa_state_e        state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

   logic             accept, last;
   logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
   logic             ch_cout, ch_msb_cin;

   assign accept = bus_if.start && (state_q != RUN);
   assign last   = (idx_q == IDXW'(NCHUNK - 1));
   assign ch_a   = a_q[int'(idx_q)*CHUNK +: CHUNK];
   assign ch_b   = b_q[int'(idx_q)*CHUNK +: CHUNK];

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a_i       (ch_a),
      .b_i       (ch_b),
      .cin_i     (carry_q),
      .sum_o     (ch_sum),
      .cout_o    (ch_cout),
      .msb_cin_o (ch_msb_cin)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last)   state_d = DONE;
         DONE:    state_d = bus_if.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus_if.busy = (state_q == RUN);
      bus_if.done = (state_q == DONE);
   end

   always_comb begin
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = bus_if.a;
         idx_d   = '0;
`ifdef SEQ_ADDER_SUBTRACT_EN
         // a - b as a + ~b + 1; cout then reads as "no borrow"
         b_d     = bus_if.sub ? ~bus_if.b : bus_if.b;
         carry_d = bus_if.sub | bus_if.cin;
`else
         b_d     = bus_if.b;
         carry_d = bus_if.cin;
`endif
      end else if (state_q == RUN) begin
         sum_d[int'(idx_q)*CHUNK +: CHUNK] = ch_sum;
         carry_d = ch_cout;
         idx_d   = last ? '0 : idx_q + 1'b1;
         if (last) begin
            cout_d = ch_cout;
            ovf_d  = ch_msb_cin ^ ch_cout;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus_if.sum      = sum_q;
   assign bus_if.cout     = cout_q;
   assign bus_if.overflow = ovf_q;
endmodule
